// File: rtl/data_sram_resp_pkg.sv
// data_sram_resp_pkg: shared widths for the data SRAM; DATA_SRAM_PERF_CNT_EN is left undefined by default.
package data_sram_resp_pkg;
  localparam int DATA_SRAM_DW = 32;
  localparam int DATA_SRAM_STRB_W = 4;
  localparam int DATA_SRAM_CNT_W = 32;
`ifdef DATA_SRAM_PERF_CNT_EN
  localparam bit DATA_SRAM_PERF_CNT_ON = 1'b1;
`else
  localparam bit DATA_SRAM_PERF_CNT_ON = 1'b0;
`endif
endpackage

// File: rtl/data_sram_resp_perf_cnt.sv
// data_sram_perf_cnt: saturating event counter with synchronous clear (clear wins over increment).
module data_sram_perf_cnt
  import data_sram_resp_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inc,
  input  logic                       clr,
  output logic [DATA_SRAM_CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp: byte-strobed single-port data SRAM with out-of-window flag; DATA_SRAM_PERF_CNT_EN builds load/store counters.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        data_sram_en,
  input  logic [DATA_SRAM_STRB_W-1:0] data_sram_wen,
  input  logic [31:0]                 data_sram_addr,
  input  logic [DATA_SRAM_DW-1:0]     data_sram_wdata,
  output logic [DATA_SRAM_DW-1:0]     data_sram_rdata,
  output logic                        oob_err,
  input  logic                        perf_clr,
  output logic [DATA_SRAM_CNT_W-1:0]  perf_ld_cnt,
  output logic [DATA_SRAM_CNT_W-1:0]  perf_st_cnt
);
  logic [DATA_SRAM_DW-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic in_win, rd, wr;
  assign idx = data_sram_addr[ADDR_WIDTH+1:2];
  assign in_win = data_sram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  assign rd = data_sram_en && data_sram_wen == '0 && in_win;
  assign wr = data_sram_en && data_sram_wen != '0 && in_win;
  // Array has no reset; a request during reset is simply dropped.
  always_ff @(posedge clk)
    if (!reset && wr)
      for (int i = 0; i < DATA_SRAM_STRB_W; i++)
        if (data_sram_wen[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
  always_ff @(posedge clk)
    if (reset) data_sram_rdata <= '0;
    else if (data_sram_en && data_sram_wen == '0) data_sram_rdata <= in_win ? mem[idx] : '0;
  always_ff @(posedge clk)
    oob_err <= !reset && data_sram_en && !in_win;
  logic unused_bits;
`ifdef DATA_SRAM_PERF_CNT_EN
  assign unused_bits = ^data_sram_addr[1:0];
  data_sram_perf_cnt u_ld (.clk(clk), .reset(reset), .inc(rd), .clr(perf_clr), .cnt(perf_ld_cnt));
  data_sram_perf_cnt u_st (.clk(clk), .reset(reset), .inc(wr), .clr(perf_clr), .cnt(perf_st_cnt));
`else
  assign unused_bits = ^{data_sram_addr[1:0], perf_clr, rd, wr};
  assign perf_ld_cnt = '0;
  assign perf_st_cnt = '0;
`endif
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: directed steps with a read-data scoreboard and a byte-lane memory model.
module tb_data_sram_resp;
  logic clk = 0, reset = 1, en = 0, clr = 0, oob;
  logic [3:0] wen = 0;
  logic [31:0] addr = 0, wdata = 0, rdata, ld_cnt, st_cnt;
  int tests = 0, fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_m [int];
  logic [31:0] hold = 0, ld_m = 0, st_m = 0;
  logic oob_m = 0;

  always #5 clk = ~clk;

  data_sram_resp dut (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata),
    .oob_err(oob), .perf_clr(clr), .perf_ld_cnt(ld_cnt), .perf_st_cnt(st_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 1;
  endfunction

  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d, input logic c);
    logic win;
    logic [31:0] word;
    int i;
    en = e; wen = w; addr = a; wdata = d; clr = c;
    win = a[31:16] == 16'h0;
    i = int'(a[15:2]);
    if (reset) begin
      exp_q.delete(); hold = 0; ld_m = 0; st_m = 0; oob_m = 0;
    end else begin
      oob_m = e && !win;
      if (e && w == 0) exp_q.push_back(win ? mem_m[i] : 32'h0);
      if (e && w != 0 && win) begin
        word = mem_m.exists(i) ? mem_m[i] : 32'h0;
        for (int b = 0; b < 4; b++) if (w[b]) word[8*b +: 8] = d[8*b +: 8];
        mem_m[i] = word;
      end
      if (c) begin
        ld_m = 0; st_m = 0;
      end else begin
        if (e && w == 0 && win) ld_m = sat_inc(ld_m);
        if (e && w != 0 && win) st_m = sat_inc(st_m);
      end
    end
    @(posedge clk); #1;
    if (exp_q.size() > 0) hold = exp_q.pop_front();
    chk("rdata", rdata, hold);
    chk("oob_err", {31'b0, oob}, {31'b0, oob_m});
`ifdef DATA_SRAM_PERF_CNT_EN
    chk("ld_cnt", ld_cnt, ld_m);
    chk("st_cnt", st_cnt, st_m);
`else
    chk("ld_cnt", ld_cnt, 32'h0);
    chk("st_cnt", st_cnt, 32'h0);
`endif
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    step(1, w, a, d, 0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1, 4'b0000, a, 32'h0, 0);
  endtask

  task automatic idle();
    step(0, 4'b0000, 32'h0, 32'h0, 0);
  endtask

  initial begin
    reset = 1;
    idle(); idle();
    reset = 0;
    chk("reset_rdata", rdata, 32'h0);
    wr(32'h100, 32'hDEADBEEF, 4'b1111);
    rd(32'h100);
    chk("full_word", rdata, 32'hDEADBEEF);
    wr(32'h100, 32'h11223344, 4'b0001);
    rd(32'h100);
    chk("lane0", rdata, 32'hDEADBE44);
    wr(32'h100, 32'h11223344, 4'b1100);
    rd(32'h100);
    chk("lane32", rdata, 32'h1122BE44);
    for (int k = 0; k < 15; k++) wr(32'h200 + 32'(4 * k), 32'hA1B2C3D4 ^ 32'(k * 32'h01010101), 4'(k + 1));
    for (int k = 0; k < 15; k++) rd(32'h200 + 32'(4 * k));
    wr(32'h0, 32'hA5A50F0F, 4'b1111);
    rd(32'h0);
    chk("b2b", rdata, 32'hA5A50F0F);
    idle(); idle(); idle();
    chk("hold", rdata, 32'hA5A50F0F);
    rd(32'h0001_0000);
    chk("oob_rd_data", rdata, 32'h0);
    chk("oob_rd_pulse", {31'b0, oob}, 32'h1);
    idle();
    chk("oob_single", {31'b0, oob}, 32'h0);
    wr(32'h0001_0000, 32'hFFFFFFFF, 4'b1111);
    rd(32'h0);
    chk("oob_wr_noalias", rdata, 32'hA5A50F0F);
    step(1, 4'b0000, 32'h100, 32'h0, 1);
    rd(32'h100); rd(32'h0); rd(32'h204);
    wr(32'h300, 32'h0BADF00D, 4'b1111); wr(32'h304, 32'h12345678, 4'b0110);
`ifdef DATA_SRAM_PERF_CNT_EN
    chk("ld3", ld_cnt, 32'd3);
    chk("st2", st_cnt, 32'd2);
    force dut.u_ld.cnt = 32'hFFFF_FFFF;
    #1 release dut.u_ld.cnt;
    ld_m = 32'hFFFF_FFFF;
    rd(32'h300);
    chk("ld_sat", ld_cnt, 32'hFFFF_FFFF);
`endif
    wr(32'h40, 32'h55AA55AA, 4'b1111);
    rd(32'h40);
    reset = 1;
    wr(32'h40, 32'hFFFFFFFF, 4'b1111);
    reset = 0;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ld", ld_cnt, 32'h0);
    chk("rst_st", st_cnt, 32'h0);
    rd(32'h40);
    chk("rst_drop", rdata, 32'h55AA55AA);
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
